pipeline_control: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline. It watches the ID and EX stages and the data-memory handshake, then drives stall, flush and bubble controls to IF, ID and EX. It also issues the branch-mispredict PC redirect and keeps a saturating stall-cycle counter for performance measurement. It sits beside the pipeline registers and owns no datapath values except the redirect PC.

---
 rtl/pipeline_control_pkg.sv | 14 +
 rtl/pipeline_control_hazard_detect.sv | 21 ++
 rtl/pipeline_control.sv | 158 +++++++++++++++
 tb/tb_pipeline_control.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg: shared encodings for the pipeline hazard controller
package pipeline_control_pkg;
  typedef enum logic [2:0] {
    CTL_RUN      = 3'd0,
    CTL_FLUSH    = 3'd1,
    CTL_MEM_WAIT = 3'd2,
    CTL_HALT     = 3'd3
  } ctl_state_t;
  localparam logic [1:0] DM_NONE = 2'd0;
  localparam logic [1:0] DM_LB = 2'd1;
  localparam logic [1:0] DM_LH = 2'd2;
  localparam logic [1:0] DM_LW = 2'd3;
  localparam logic [1:0] WB_HICCUP = 2'd3;
endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// hazard_detect: combinational load-use and data-memory stall detection
//   in:  id_rs1/id_rs2, id_uses_rs1/id_uses_rs2, ex_read_status, ex_dest, dmem_req, dmem_ready
//   out: load_use (ID reads the register a load in EX is producing), mem_stall (memory access not done)
module hazard_detect
  import pipeline_control_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [1:0] ex_read_status,
  input  logic [4:0] ex_dest,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       load_use,
  output logic       mem_stall
);
  assign load_use = ex_read_status != DM_NONE && ex_dest != 5'd0 &&
                    ((id_uses_rs1 && id_rs1 == ex_dest) || (id_uses_rs2 && id_rs2 == ex_dest));
  assign mem_stall = dmem_req && !dmem_ready;
endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: stall/flush/bubble sequencing, mispredict redirect and stall-cycle counter
//   in:  clk, reset (async, active low), ID source regs, EX load info, mispredict/new_pc,
//        dmem_req/dmem_ready, halt_request
//   out: stall_if/stall_id/stall_ex, bubble_ex, flush_id (combinational);
//        redirect_valid/redirect_pc, ctl_state, stall_count (registered); halted
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [1:0]       ex_read_status,
  input  logic [4:0]       ex_dest,
  input  logic             mispredict,
  input  logic [31:0]      new_pc,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_request,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             halted,
  output logic [2:0]       ctl_state,
  output logic [CNT_W-1:0] stall_count
);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  ctl_state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic pending, pending_nx;
  logic [31:0] pending_pc, pending_pc_nx, redirect_pc_nx;
  logic redirect_valid_nx;
  logic load_use, mem_stall;
  logic any_stall;

  hazard_detect u_hazard (
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .ex_read_status(ex_read_status),
    .ex_dest(ex_dest),
    .dmem_req(dmem_req),
    .dmem_ready(dmem_ready),
    .load_use(load_use),
    .mem_stall(mem_stall)
  );

  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    pending_nx = pending;
    pending_pc_nx = pending_pc;
    redirect_pc_nx = redirect_pc;
    redirect_valid_nx = 1'b0;
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    bubble_ex = 1'b0;
    flush_id = 1'b0;
    halted = 1'b0;
    if (!reset) begin
      bubble_ex = 1'b1;
      flush_id = 1'b1;
    end else begin
      case (state)
        CTL_RUN: begin
          if (mem_stall) begin
            {stall_if, stall_id, stall_ex} = 3'b111;
            state_nx = CTL_MEM_WAIT;
            if (mispredict) begin
              pending_nx = 1'b1;
              pending_pc_nx = new_pc;
            end
          end else if (mispredict) begin
            flush_id = 1'b1;
            bubble_ex = 1'b1;
            redirect_pc_nx = new_pc;
            redirect_valid_nx = 1'b1;
            cnt_nx = FLUSH_INIT;
            state_nx = CTL_FLUSH;
          end else if (load_use) begin
            {stall_if, stall_id, bubble_ex} = 3'b111;
          end else if (halt_request) begin
            {stall_if, bubble_ex, flush_id} = 3'b111;
            state_nx = CTL_HALT;
          end
        end
        CTL_FLUSH: begin
          flush_id = 1'b1;
          bubble_ex = 1'b1;
          stall_ex = mem_stall;
          if (mispredict) begin
            redirect_pc_nx = new_pc;
            redirect_valid_nx = 1'b1;
            cnt_nx = FLUSH_INIT;
          end else if (!mem_stall) begin
            state_nx = cnt == 3'd0 ? CTL_RUN : CTL_FLUSH;
            cnt_nx = cnt == 3'd0 ? cnt : cnt - 3'd1;
          end
        end
        CTL_MEM_WAIT: begin
          if (mem_stall) begin
            {stall_if, stall_id, stall_ex} = 3'b111;
          end else if (pending) begin
            // the instructions released this cycle are on the wrong path
            flush_id = 1'b1;
            bubble_ex = 1'b1;
            redirect_pc_nx = pending_pc;
            redirect_valid_nx = 1'b1;
            cnt_nx = FLUSH_INIT;
            pending_nx = 1'b0;
            state_nx = CTL_FLUSH;
          end else begin
            state_nx = CTL_RUN;
          end
        end
        CTL_HALT: begin
          {stall_if, stall_id, stall_ex} = 3'b111;
          halted = 1'b1;
        end
        default: state_nx = CTL_RUN;
      endcase
    end
  end

  assign any_stall = stall_if | stall_id | stall_ex;
  assign ctl_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CTL_RUN;
      cnt <= 3'd0;
      pending <= 1'b0;
      pending_pc <= 32'd0;
      redirect_pc <= 32'd0;
      redirect_valid <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pending <= pending_nx;
      pending_pc <= pending_pc_nx;
      redirect_pc <= redirect_pc_nx;
      redirect_valid <= redirect_valid_nx;
      stall_count <= (any_stall && stall_count != '1) ? stall_count + CNT_W'(1) : stall_count;
    end
  end
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed self-checking bench for pipeline_control
module tb_pipeline_control;
  import pipeline_control_pkg::*;
  logic clk, reset;
  logic [4:0] id_rs1, id_rs2, ex_dest;
  logic id_uses_rs1, id_uses_rs2, mispredict, dmem_req, dmem_ready, halt_request;
  logic [1:0] ex_read_status;
  logic [31:0] new_pc;
  logic stall_if, stall_id, stall_ex, bubble_ex, flush_id, redirect_valid, halted;
  logic [31:0] redirect_pc;
  logic [2:0] ctl_state;
  logic [15:0] stall_count;
  logic stall_if_n, stall_id_n, stall_ex_n, bubble_ex_n, flush_id_n, redirect_valid_n, halted_n;
  logic [31:0] redirect_pc_n;
  logic [2:0] ctl_state_n;
  logic [3:0] stall_count_n;
  logic [6:0] ctl;
  int errors = 0;
  int checks = 0;

  assign ctl = {stall_if, stall_id, stall_ex, bubble_ex, flush_id, redirect_valid, halted};

  pipeline_control u0 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_read_status(ex_read_status),
    .ex_dest(ex_dest), .mispredict(mispredict), .new_pc(new_pc), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .halt_request(halt_request), .stall_if(stall_if),
    .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
    .ctl_state(ctl_state), .stall_count(stall_count)
  );

  pipeline_control #(.FLUSH_CYCLES(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_read_status(ex_read_status),
    .ex_dest(ex_dest), .mispredict(mispredict), .new_pc(new_pc), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .halt_request(halt_request), .stall_if(stall_if_n),
    .stall_id(stall_id_n), .stall_ex(stall_ex_n), .bubble_ex(bubble_ex_n), .flush_id(flush_id_n),
    .redirect_valid(redirect_valid_n), .redirect_pc(redirect_pc_n), .halted(halted_n),
    .ctl_state(ctl_state_n), .stall_count(stall_count_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_dest = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_read_status = DM_NONE; mispredict = 0; new_pc = 0; dmem_req = 0;
    dmem_ready = 0; halt_request = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    idle();
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic test_reset();
    reset = 0;
    idle();
    #2;
    checks++; if (ctl !== 7'b0001100) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0001100); end
    checks++; if (ctl_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", ctl_state); end
    checks++; if (stall_count !== 16'd0 || redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_regs got cnt=%0d pc=%h exp 0", stall_count, redirect_pc); end
    @(negedge clk);
    reset = 1;
    tick();
    checks++; if (ctl !== 7'b0 || ctl_state !== 3'd0) begin errors++; $display("FAIL run_idle got ctl=%b state=%0d exp 0", ctl, ctl_state); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_read_status = DM_LW; ex_dest = 5; id_rs2 = 5; id_uses_rs2 = 1;
    #1;
    checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL load_use_ctl got=%b exp=%b", ctl, 7'b1101000); end
    tick();
    idle();
    #1;
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL load_use_count got=%0d exp=1", stall_count); end
    checks++; if (ctl !== 7'b0 || ctl_state !== 3'd0) begin errors++; $display("FAIL load_use_after got ctl=%b state=%0d exp 0", ctl, ctl_state); end
    ex_read_status = DM_LB; ex_dest = 0; id_rs1 = 0; id_uses_rs1 = 1;
    #1;
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL load_use_x0 got=%b exp=0", ctl); end
    ex_dest = 7; id_rs1 = 7; id_uses_rs1 = 0;
    #1;
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL load_use_unused got=%b exp=0", ctl); end
    id_uses_rs1 = 1;
    #1;
    checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL load_use_rs1 got=%b exp=%b", ctl, 7'b1101000); end
    ex_read_status = DM_NONE;
    #1;
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL load_use_noload got=%b exp=0", ctl); end
    idle();
  endtask

  task automatic test_mispredict();
    do_reset();
    mispredict = 1; new_pc = 32'h40;
    #1;
    checks++; if (ctl !== 7'b0001100) begin errors++; $display("FAIL mp_cycle0 got=%b exp=%b", ctl, 7'b0001100); end
    tick();
    idle();
    #1;
    checks++; if (ctl !== 7'b0001110 || ctl_state !== 3'd1) begin errors++; $display("FAIL mp_flush1 got ctl=%b state=%0d exp ctl=0001110 state=1", ctl, ctl_state); end
    checks++; if (redirect_pc !== 32'h40) begin errors++; $display("FAIL mp_pc got=%h exp=%h", redirect_pc, 32'h40); end
    checks++; if (ctl_state_n !== 3'd1) begin errors++; $display("FAIL mp_f1_state got=%0d exp=1", ctl_state_n); end
    tick();
    checks++; if (ctl !== 7'b0001100 || ctl_state !== 3'd1) begin errors++; $display("FAIL mp_flush2 got ctl=%b state=%0d exp ctl=0001100 state=1", ctl, ctl_state); end
    checks++; if (ctl_state_n !== 3'd0) begin errors++; $display("FAIL mp_f1_done got=%0d exp=0", ctl_state_n); end
    tick();
    checks++; if (ctl !== 7'b0 || ctl_state !== 3'd0 || redirect_pc !== 32'h40) begin errors++; $display("FAIL mp_done got ctl=%b state=%0d pc=%h exp 0/0/40", ctl, ctl_state, redirect_pc); end
  endtask

  task automatic test_mem_mispredict();
    do_reset();
    dmem_req = 1; dmem_ready = 0; mispredict = 1; new_pc = 32'h1234_5678;
    #1;
    checks++; if (ctl !== 7'b1110000) begin errors++; $display("FAIL mm_run got=%b exp=%b", ctl, 7'b1110000); end
    tick();
    new_pc = 32'hDEAD_0000;
    #1;
    checks++; if (ctl !== 7'b1110000 || ctl_state !== 3'd2) begin errors++; $display("FAIL mm_wait got ctl=%b state=%0d exp ctl=1110000 state=2", ctl, ctl_state); end
    tick();
    tick();
    tick();
    checks++; if (stall_count !== 16'd4) begin errors++; $display("FAIL mm_count got=%0d exp=4", stall_count); end
    dmem_ready = 1; mispredict = 0;
    #1;
    checks++; if ({stall_if, stall_id, stall_ex} !== 3'b000) begin errors++; $display("FAIL mm_ready got=%b exp=000", {stall_if, stall_id, stall_ex}); end
    tick();
    idle();
    #1;
    checks++; if (ctl_state !== 3'd1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h1234_5678) begin errors++; $display("FAIL mm_redirect got state=%0d rv=%b pc=%h exp 1/1/12345678", ctl_state, redirect_valid, redirect_pc); end
    checks++; if (stall_count !== 16'd4) begin errors++; $display("FAIL mm_count_hold got=%0d exp=4", stall_count); end
    tick();
    checks++; if (ctl_state !== 3'd1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL mm_flush2 got state=%0d rv=%b exp 1/0", ctl_state, redirect_valid); end
    tick();
    checks++; if (ctl_state !== 3'd0) begin errors++; $display("FAIL mm_done got=%0d exp=0", ctl_state); end
  endtask

  task automatic test_priority();
    do_reset();
    mispredict = 1; new_pc = 32'h80; halt_request = 1;
    ex_read_status = DM_LW; ex_dest = 3; id_rs1 = 3; id_uses_rs1 = 1;
    #1;
    checks++; if (ctl !== 7'b0001100) begin errors++; $display("FAIL prio_ctl got=%b exp=%b", ctl, 7'b0001100); end
    tick();
    idle();
    #1;
    checks++; if (ctl_state !== 3'd1 || halted !== 1'b0 || redirect_pc !== 32'h80) begin errors++; $display("FAIL prio_flush got state=%0d halted=%b pc=%h exp 1/0/80", ctl_state, halted, redirect_pc); end
    tick();
    tick();
    checks++; if (ctl_state !== 3'd0 || halted !== 1'b0) begin errors++; $display("FAIL prio_done got state=%0d halted=%b exp 0/0", ctl_state, halted); end
  endtask

  task automatic test_halt();
    int bad;
    do_reset();
    halt_request = 1;
    #1;
    checks++; if (ctl !== 7'b1001100) begin errors++; $display("FAIL halt_req got=%b exp=%b", ctl, 7'b1001100); end
    tick();
    halt_request = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (ctl_state !== 3'd3 || ctl !== 7'b1110001) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL halt_hold got %0d bad cycles exp 0", bad); end
    #2;
    reset = 0;
    #1;
    checks++; if (ctl_state !== 3'd0 || bubble_ex !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL halt_reset got state=%0d bubble=%b halted=%b exp 0/1/0", ctl_state, bubble_ex, halted); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL halt_reset_cnt got=%0d exp=0", stall_count); end
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 21; i++) tick();
    checks++; if (stall_count_n !== 4'd15) begin errors++; $display("FAIL sat_narrow got=%0d exp=15", stall_count_n); end
    checks++; if (stall_count !== 16'd21) begin errors++; $display("FAIL sat_wide got=%0d exp=21", stall_count); end
    dmem_ready = 1;
    tick();
    idle();
    #1;
    checks++; if (ctl_state !== 3'd0 || stall_count_n !== 4'd15) begin errors++; $display("FAIL sat_exit got state=%0d cnt=%0d exp 0/15", ctl_state, stall_count_n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mispredict();
    test_mem_mispredict();
    test_priority();
    test_halt();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
